spi_slave_register_bank: RTL
============================

Name: spi_slave_register_bank

Overview:
Synthesizable, parametrised SPI slave with an internal register file. It is the next generation of the behavioural SPI slave model used in SPI master bring-up, and can sit opposite spi_master in silicon. It decodes the master's frame of {read_write, address, data}, supports all four CPOL/CPHA modes and multi-word bursts with address auto-increment, and exposes a local-side access port.

Parameters:
DATA_WIDTH, 16, bits per data word.
ADDRESS_WIDTH, 15, bits of address in the frame header.
MEMORY_DEPTH, 16, register file words; power of two, at most 2**ADDRESS_WIDTH.

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
serial_clock  input  1  SCK from master, asynchronous to clock
chip_select  input  1  active-low slave select
serial_in  input  1  MOSI
clock_polarity  input  1  CPOL; static while chip_select is high
clock_phase  input  1  CPHA; static while chip_select is high
serial_out  output  1  MISO
busy  output  1  high while a frame is active
write_valid  output  1  one-cycle pulse when an SPI write word commits
write_address  output  ADDRESS_WIDTH  address of the committed word
write_data  output  DATA_WIDTH  committed word
local_write_enable  input  1  local write strobe
local_read_enable  input  1  local read strobe
local_address  input  $clog2(MEMORY_DEPTH)  local index
local_data  input  DATA_WIDTH  local write data
local_read_data  output  DATA_WIDTH  registered local read result
local_collision  output  1  one-cycle pulse when a local write is dropped
frame_error_count  output  16  see Optional Feature

Behaviour:
- Reset values: all outputs 0, register file contents 0, state IDLE.
- serial_clock, chip_select and serial_in each pass through a 2-FF synchroniser. Edges are detected on the synchronised serial_clock.
- Sample edge is rising SCK when CPOL^CPHA==0, otherwise falling. The shift edge is the opposite edge.
- Timing constraint: SCK high and low times must each be ≥4 clock periods.
- Frame format, MSB first: bit 0 is read_write (1 = read), then ADDRESS_WIDTH address bits, then one or more DATA_WIDTH words.
- States:
  - IDLE: wait for synchronised chip_select low, then go to HEADER and assert busy.
  - HEADER: shift sampled bits in. After ADDRESS_WIDTH+1 samples, latch rw and address, then go to DATA. On a read, register[address mod MEMORY_DEPTH] loads the MISO shift register in the same cycle.
  - DATA, write: after DATA_WIDTH samples, commit to register[address mod MEMORY_DEPTH] in the next cycle and pulse write_valid with write_address and write_data. Then increment address (wraps at 2**ADDRESS_WIDTH) and stay in DATA for the next burst word.
  - DATA, read: on every shift edge, serial_out advances one bit. At the end of each word, address increments and the next word is loaded before the following shift edge.
- CPHA=0 reads: the data MSB is driven on the first shift edge after the last header sample. The serial_out value during the header is 0.
- CPHA=1: the first SCK edge of the frame is a shift edge and is ignored in HEADER.
- chip_select rising in any state returns to IDLE next cycle and clears busy and serial_out.
  - A partial data word is discarded, with no write.
  - A complete header with zero data words is not an error.
  - A partial header or partial data word is a frame error.
- serial_out is 0 whenever the state is IDLE.
- Local port: local_read_enable returns register[local_address] on local_read_data one cycle later. local_write_enable writes the register file.
- If a local write and an SPI commit occur in the same cycle, SPI wins: the local write is dropped and local_collision pulses. This holds even if the indices differ (single write port).
- Reset asserted mid-frame: immediate return to the reset values; the register file is cleared.

Optional Feature:
Macro SPI_SLAVE_FRAME_ERROR_COUNT_EN.
- Defined: frame_error_count increments, saturating at 16'hFFFF, on each frame error defined above. Reset value is 0.
- Undefined: frame_error_count is tied to 0 and no counter logic exists.

Test Plan:
- Mode 0, write addr 15'h0003 data 16'hA5C3, then local read index 3 -> write_valid one pulse with address 3 and data A5C3; local_read_data=A5C3.
- Mode 3, preload index 5=16'h1234 and 6=16'hBEEF locally, then burst read of 2 words from addr 5 -> MISO carries 1234 then BEEF; busy drops within 3 cycles of chip_select rising.
- Mode 1 burst write of 3 words from addr 15'h000F with depth 16 -> writes to indices 15, 0, 1; write_address values F, 10, 11.
- Mode 2, chip_select raised after 8 data bits -> no write_valid; frame_error_count=1 with the macro, 0 without.
- Local write to index 2 in the same cycle as an SPI commit to index 2 with 16'h00FF -> register holds 00FF; local_collision pulses once.
- reset_n pulsed low mid-header -> all outputs 0 and the register file reads 0; the next full write frame succeeds.

Source files
------------

// File: rtl/spi_slave_register_bank.sv
// SPI slave with an internal register file and a local access port.
// Frame: rw bit (1 = read), ADDRESS_WIDTH address bits, then DATA_WIDTH-bit
// words MSB first with address auto-increment. All four CPOL/CPHA modes.
// Optional feature macro: SPI_SLAVE_FRAME_ERROR_COUNT_EN (frame error counter).
`timescale 1ns/1ps
module spi_slave_register_bank #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 15,
  parameter int MEMORY_DEPTH  = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            serial_clock,
  input  logic                            chip_select,
  input  logic                            serial_in,
  input  logic                            clock_polarity,
  input  logic                            clock_phase,
  output logic                            serial_out,
  output logic                            busy,
  output logic                            write_valid,
  output logic [ADDRESS_WIDTH-1:0]        write_address,
  output logic [DATA_WIDTH-1:0]           write_data,
  input  logic                            local_write_enable,
  input  logic                            local_read_enable,
  input  logic [$clog2(MEMORY_DEPTH)-1:0] local_address,
  input  logic [DATA_WIDTH-1:0]           local_data,
  output logic [DATA_WIDTH-1:0]           local_read_data,
  output logic                            local_collision,
  output logic [15:0]                     frame_error_count
);

  localparam int IDX_W    = $clog2(MEMORY_DEPTH);
  localparam int MAX_BITS = (ADDRESS_WIDTH + 1 > DATA_WIDTH) ? ADDRESS_WIDTH + 1 : DATA_WIDTH;
  localparam int CNT_W    = $clog2(MAX_BITS);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDRESS_WIDTH);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t state, next_state;

  logic sck_meta, sck_s, sck_prev;
  logic cs_meta, cs_s;
  logic mosi_meta, mosi_s;
  logic sck_rise, sck_fall, sample_edge, shift_edge, mode_odd;

  logic [CNT_W-1:0]         bit_cnt;
  logic [ADDRESS_WIDTH-1:0] hdr;
  logic [ADDRESS_WIDTH-1:0] addr, addr_full, addr_next;
  logic                     rw;
  logic [DATA_WIDTH-2:0]    rx_word;
  logic [DATA_WIDTH-1:0]    tx_reg;
  logic [DATA_WIDTH-1:0]    mem [MEMORY_DEPTH];

  // Two-flop synchronisers; chip select idles deasserted so reset release
  // never looks like the start of a frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_meta  <= 1'b0;
      sck_s     <= 1'b0;
      sck_prev  <= 1'b0;
      cs_meta   <= 1'b1;
      cs_s      <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      sck_meta  <= serial_clock;
      sck_s     <= sck_meta;
      sck_prev  <= sck_s;
      cs_meta   <= chip_select;
      cs_s      <= cs_meta;
      mosi_meta <= serial_in;
      mosi_s    <= mosi_meta;
    end
  end

  assign sck_rise    = sck_s & ~sck_prev;
  assign sck_fall    = ~sck_s & sck_prev;
  assign mode_odd    = clock_polarity ^ clock_phase;
  assign sample_edge = mode_odd ? sck_fall : sck_rise;
  assign shift_edge  = mode_odd ? sck_rise : sck_fall;

  assign addr_full = {hdr[ADDRESS_WIDTH-2:0], mosi_s};
  assign addr_next = addr + 1'b1;
  assign busy      = (state != IDLE);

  // Frame state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decode; a deasserted select aborts from any state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!cs_s) next_state = HEADER;
      HEADER: begin
        if (cs_s)                                       next_state = IDLE;
        else if (sample_edge && (bit_cnt == HDR_LAST))  next_state = DATA;
      end
      DATA:    if (cs_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shift datapath: header capture, write word assembly, read word shifting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt       <= '0;
      hdr           <= '0;
      addr          <= '0;
      rw            <= 1'b0;
      rx_word       <= '0;
      tx_reg        <= '0;
      serial_out    <= 1'b0;
      write_valid   <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      write_valid <= 1'b0;
      case (state)
        HEADER: begin
          serial_out <= 1'b0;
          if (!cs_s && sample_edge) begin
            hdr <= addr_full;
            if (bit_cnt == HDR_LAST) begin
              rw      <= hdr[ADDRESS_WIDTH-1];
              addr    <= addr_full;
              bit_cnt <= '0;
              if (hdr[ADDRESS_WIDTH-1]) tx_reg <= mem[addr_full[IDX_W-1:0]];
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (cs_s) begin
            serial_out <= 1'b0;
            bit_cnt    <= '0;
          end else begin
            if (rw && shift_edge) begin
              serial_out <= tx_reg[DATA_WIDTH-1];
              tx_reg     <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
            end
            if (sample_edge) begin
              rx_word <= {rx_word[DATA_WIDTH-3:0], mosi_s};
              if (bit_cnt == DATA_LAST) begin
                // Word boundary: reads preload the next word here, ahead of
                // the shift edge that emits its MSB.
                bit_cnt <= '0;
                addr    <= addr_next;
                if (rw) begin
                  tx_reg <= mem[addr_next[IDX_W-1:0]];
                end else begin
                  write_valid   <= 1'b1;
                  write_address <= addr;
                  write_data    <= {rx_word, mosi_s};
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          serial_out <= 1'b0;
          bit_cnt    <= '0;
        end
      endcase
    end
  end

  // Register file: single write port, SPI commit has priority over local
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MEMORY_DEPTH; i++) mem[IDX_W'(i)] <= '0;
      local_read_data <= '0;
      local_collision <= 1'b0;
    end else begin
      if (write_valid)             mem[write_address[IDX_W-1:0]] <= write_data;
      else if (local_write_enable) mem[local_address]            <= local_data;
      local_collision <= write_valid & local_write_enable;
      if (local_read_enable) local_read_data <= mem[local_address];
    end
  end

`ifdef SPI_SLAVE_FRAME_ERROR_COUNT_EN
  logic frame_error;
  assign frame_error = cs_s && ((state == HEADER) || ((state == DATA) && (bit_cnt != '0)));

  // Saturating count of aborted headers and partial data words
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                        frame_error_count <= '0;
    else if (frame_error && (frame_error_count != '1))   frame_error_count <= frame_error_count + 1'b1;
  end
`else
  assign frame_error_count = '0;
`endif

endmodule
